// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - FIFO-fed PWM DAC sample scheduler
//
// Buffers DAC sample codes in a small FIFO. While running, each code is played
// as a PWM waveform whose period is 2^CODE_WIDTH clk cycles, and each code is
// held for PERIODS_PER_SAMPLE periods.
//
// Ports:
//   clk           - clock, all logic on the rising edge
//   rst           - synchronous active-high reset
//   enable        - run request
//   sample_in     - sample code to enqueue
//   sample_valid  - sample_in is valid
//   sample_ready  - FIFO can accept (registered-only path, equals !full)
//   pwm_out       - registered PWM bit
//   fifo_count    - FIFO occupancy
//   underflow     - sticky flag, a sample load found the FIFO empty
//   clr_underflow - clears underflow (a simultaneous new underflow wins)
//   running       - high while in RUN
module dac_sample_scheduler #(
  parameter int CODE_WIDTH         = 10,
  parameter int PERIODS_PER_SAMPLE = 4,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [CODE_WIDTH-1:0]         sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow,
  input  logic                          clr_underflow,
  output logic                          running
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [PW-1:0]         PERIOD_LAST = PW'(PERIODS_PER_SAMPLE - 1);
  localparam logic [CODE_WIDTH-1:0] PWM_MAX     = {CODE_WIDTH{1'b1}};

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [CODE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CODE_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CODE_WIDTH-1:0] cur_code_q, cur_code_d;
  logic [PW-1:0]         period_cnt_q, period_cnt_d;
  logic                  pwm_q, pwm_d;
  logic                  underflow_q, underflow_d;
  logic                  push, pop, full, empty, uf_set, period_end;

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  // ready depends only on registered occupancy, so no input-to-output path
  assign push       = sample_valid && !full;
  assign period_end = (pwm_cnt_q == PWM_MAX);

  always_comb begin
    state_d      = state_q;
    pwm_cnt_d    = pwm_cnt_q;
    period_cnt_d = period_cnt_q;
    cur_code_d   = cur_code_q;
    pwm_d        = 1'b0;
    pop          = 1'b0;
    uf_set       = 1'b0;
    case (state_q)
      ST_STOP: begin
        pwm_cnt_d    = '0;
        period_cnt_d = '0;
        if (enable && !empty) begin
          state_d    = ST_RUN;
          pop        = 1'b1;
          cur_code_d = mem_q[rd_ptr_q];
        end
      end
      ST_RUN: begin
        pwm_cnt_d = pwm_cnt_q + CODE_WIDTH'(1);
        pwm_d     = (pwm_cnt_q < cur_code_q);
        if (period_end) begin
          if (!enable) begin
            // enable is only looked at here, so a short glitch within a
            // period is ignored and the period always completes
            state_d      = ST_STOP;
            period_cnt_d = '0;
          end else if (period_cnt_q == PERIOD_LAST) begin
            period_cnt_d = '0;
            if (!empty) begin
              pop        = 1'b1;
              cur_code_d = mem_q[rd_ptr_q];
            end else begin
              // a same-cycle push is not bypassed; the old code is held
              uf_set = 1'b1;
            end
          end else begin
            period_cnt_d = period_cnt_q + PW'(1);
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
    underflow_d = uf_set | (underflow_q & ~clr_underflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pwm_cnt_q    <= '0;
      period_cnt_q <= '0;
      cur_code_q   <= '0;
      pwm_q        <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_cnt_q    <= pwm_cnt_d;
      period_cnt_q <= period_cnt_d;
      cur_code_q   <= cur_code_d;
      pwm_q        <= pwm_d;
      underflow_q  <= underflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset; the cleared pointers make old contents invisible
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  assign sample_ready = !full;
  assign pwm_out      = pwm_q;
  assign fifo_count   = count_q;
  assign underflow    = underflow_q;
  assign running      = (state_q == ST_RUN);

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - directed self-checking bench for dac_sample_scheduler
module tb_dac_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       pwm_out;
  logic [2:0] fifo_count;
  logic       underflow;
  logic       clr_underflow;
  logic       running;

  int tests_run    = 0;
  int tests_failed = 0;
  int highs;

  dac_sample_scheduler #(
    .CODE_WIDTH(4),
    .PERIODS_PER_SAMPLE(2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pwm_out(pwm_out),
    .fifo_count(fifo_count),
    .underflow(underflow),
    .clr_underflow(clr_underflow),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    sample_in    = 4'(v);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic count_highs(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      h += int'(pwm_out);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b0;
    sample_valid  = 1'b0;
    clr_underflow = 1'b0;
    sample_in     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count", fifo_count, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_pwm", pwm_out, 0);
    check("rst_underflow", underflow, 0);
    check("rst_running", running, 0);

    // Scenario 1: code 5 for two periods
    push(5);
    check("s1_count", fifo_count, 1);
    enable = 1'b1;
    tick();
    check("s1_running", running, 1);
    check("s1_count_after_pop", fifo_count, 0);
    count_highs(16, highs);
    check("s1_period1_highs", highs, 5);
    count_highs(16, highs);
    check("s1_period2_highs", highs, 5);

    // Scenario 2: fill the FIFO, a held fifth sample is refused
    do_reset();
    sample_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample_in = 4'(i);
      tick();
    end
    check("s2_count_full", fifo_count, 4);
    check("s2_ready_full", sample_ready, 0);
    sample_in = 4'd9;
    tick();
    sample_valid = 1'b0;
    check("s2_count_held", fifo_count, 4);

    // Scenario 3: single sample, underflow at cycle 32 and 64
    do_reset();
    push(8);
    enable = 1'b1;
    tick();
    count_highs(31, highs);
    check("s3_no_underflow_c31", underflow, 0);
    tick();
    highs += int'(pwm_out);
    check("s3_highs_32", highs, 16);
    check("s3_underflow_c32", underflow, 1);
    check("s3_still_running", running, 1);
    clr_underflow = 1'b1;
    tick();
    clr_underflow = 1'b0;
    check("s3_cleared", underflow, 0);
    highs = int'(pwm_out);
    for (int i = 0; i < 30; i++) begin
      tick();
      highs += int'(pwm_out);
    end
    check("s3_no_underflow_c63", underflow, 0);
    tick();
    highs += int'(pwm_out);
    check("s3_underflow_c64", underflow, 1);
    check("s3_highs_64", highs, 16);

    // Scenario 4: codes 0 then 15
    do_reset();
    push(0);
    push(15);
    enable = 1'b1;
    tick();
    count_highs(32, highs);
    check("s4_code0_highs", highs, 0);
    count_highs(15, highs);
    check("s4_code15_p1_first15", highs, 15);
    tick();
    check("s4_code15_low_cycle", pwm_out, 0);
    count_highs(16, highs);
    check("s4_code15_p2_highs", highs, 15);

    // Scenario 5: drop enable at pwm_cnt=3
    do_reset();
    push(6);
    push(7);
    enable = 1'b1;
    tick();
    check("s5_count_after_start", fifo_count, 1);
    tick();
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("s5_running_c15", running, 1);
    tick();
    check("s5_stopped_c16", running, 0);
    check("s5_count_kept", fifo_count, 1);
    tick();
    check("s5_pwm_stop", pwm_out, 0);
    check("s5_running_stop", running, 0);
    check("s5_count_stop", fifo_count, 1);

    // Scenario 6a: reset mid-run with three samples buffered
    do_reset();
    for (int i = 1; i <= 4; i++) push(i);
    enable = 1'b1;
    tick();
    check("s6_count3", fifo_count, 3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    enable = 1'b0;
    check("s6_rst_count", fifo_count, 0);
    check("s6_rst_pwm", pwm_out, 0);
    check("s6_rst_running", running, 0);
    check("s6_rst_underflow", underflow, 0);
    check("s6_rst_ready", sample_ready, 1);

    // Scenario 6b: simultaneous push and pop at count 2, order 10,11,12
    push(10);
    push(11);
    enable       = 1'b1;
    sample_in    = 4'd12;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("s6_pushpop_count", fifo_count, 2);
    count_highs(16, highs);
    check("s6_order_first", highs, 10);
    count_highs(16, highs);
    count_highs(16, highs);
    check("s6_order_second", highs, 11);
    check("s6_count_after_second", fifo_count, 1);
    count_highs(16, highs);
    count_highs(16, highs);
    check("s6_order_third", highs, 12);
    check("s6_count_after_third", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
